rtc_bus_engine: RTL and testbench
=================================

# rtc_bus_engine

Bus engine that executes a single RTC register access on the multiplexed address/data bus.
- The general control FSM decides the transaction direction on `RW` (1 = read, 0 = write), supplies address and data, and pulses `start`.
- This block drives the bus strobes, the address phase, and the data phase, and captures read data.
- It returns `done` with `rdata`, so it is the executing end of the read/write protocol that the control FSM requests.

## Interface
Parameters:
- `PHASE_CYCLES`, default 74 (8'h4a): clock cycles per bus phase. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock; every register updates on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `RW`  in  1  1 = read, 0 = write. Latched when `start` is accepted.
- `addr`  in  8  RTC register address. Latched when `start` is accepted.
- `wdata`  in  8  write data. Latched when `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance through DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `rdata`  out  8  captured read data. Held until the next read completes.
- `cs_n`, `rd_n`, `wr_n`, `ad_n`  out  1 each  chip select, read strobe, write strobe, and address/data select (0 = address). All are active-low.
- `ad_out`  out  8  bus drive value.
- `ad_oe`  out  1  bus output enable.
- `ad_in`  in  8  bus sample value.

## Operation
- States: IDLE, ADDR, GAP1, DATA, GAP2, DONE.
- A phase counter, 8 bits, is loaded with `PHASE_CYCLES-1` on entry to every timed state. The state advances when the counter reaches 0.
- IDLE:
  - All strobes high, `ad_oe`=0, `busy`=0.
  - `start`=1 latches RW/addr/wdata and moves to ADDR.
- ADDR: `cs_n`=0, `ad_n`=0, `wr_n`=0, `ad_oe`=1, `ad_out`=addr. Moves to GAP1.
- GAP1: `cs_n`=1, all strobes high, `ad_oe`=0. Moves to DATA.
- DATA, read: `cs_n`=0, `ad_n`=1, `rd_n`=0, `ad_oe`=0. `rdata` samples `ad_in` on the last DATA cycle.
- DATA, write: `cs_n`=0, `ad_n`=1, `wr_n`=0, `ad_oe`=1, `ad_out`=wdata.
- GAP2: same outputs as GAP1. Moves to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=1. Returns to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- Changes on RW/addr/wdata after acceptance have no effect on the current transaction.
- `rd_n` and `wr_n` are never low in the same cycle.
- `ad_oe` is 0 whenever `rd_n`=0.
- `ad_out`=0 whenever `ad_oe`=0.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `cs_n`=`rd_n`=`wr_n`=`ad_n`=1, `ad_oe`=0, `ad_out`=0, `rdata`=0, `busy`=0, `done`=0.
- Cycle numbering, with `start` accepted at edge 0 and P = `PHASE_CYCLES`:

| Phase | Cycles |
|---|---|
| ADDR | 1..P |
| GAP1 | P+1..2P |
| DATA | 2P+1..3P |
| GAP2 | 3P+1..4P |
| DONE | 4P+1 |
| IDLE | 4P+2 |

- Latency from `start` to `done` is 4P+1 cycles.
- The earliest next acceptance is at cycle 4P+2.
- `rdata` is valid from the `done` cycle onward.
- P=1 is legal: each phase is a single cycle.
- Reset asserted mid-transaction:
  - All outputs take their reset values immediately (asynchronously).
  - The transaction is abandoned.
  - No `done` is issued.
  - `rdata` is cleared.
- `start` in the same cycle that reset deasserts is ignored. It is sampled from the first clock edge after release.

## Configuration
- `RTC_BUS_GAP_EN` defined: the GAP1 and GAP2 recovery phases are present, and latency is 4P+1.
- Not defined: GAP1 and GAP2 are removed.
  - The sequence becomes ADDR → DATA → DONE, and latency is 2P+1.
  - `cs_n` stays low across the ADDR→DATA boundary.
  - `ad_n` rises and the strobe switches on the first DATA cycle.

## Structure
- Package `rtc_bus_pkg` holds:
  - the state enum encoding;
  - the `PHASE_CYCLES` default constant;
  - the RW encoding constants `RW_READ`=1 and `RW_WRITE`=0.
- One sub-module, `rtc_phase_timer`: a loadable 8-bit down-counter with a `load` input and a `zero` flag output, instantiated once.
- The FSM and output registers stay in the top module.

## Test plan
Unless noted, P=4 and `RTC_BUS_GAP_EN` is defined.
- **Write:** addr=0x21, wdata=0x35, RW=0.
  - Cycles 1-4: `ad_n`=0, `wr_n`=0, `ad_out`=0x21.
  - Cycles 9-12: `wr_n`=0, `ad_out`=0x35.
  - `done` at cycle 17.
  - `rd_n` stays 1 throughout.
- **Read:** addr=0x22, RW=1, `ad_in`=0x59 during DATA.
  - `rd_n`=0 in cycles 9-12 with `ad_oe`=0.
  - `rdata`=0x59 at the `done` cycle (17), and holds afterwards.
- **Ignored request:** `start` pulsed at cycle 6 with addr=0x99. No effect: the transaction completes with the original address, and there is exactly one `done`.
- **Reset mid-operation:** `Reset` driven low at cycle 10 of a read.
  - In the same cycle all strobes go 1, `ad_oe`=0, `busy`=0.
  - No `done` follows.
  - After release, the next read completes normally.
- **P=1, back-to-back:** two writes, the second `start` held high continuously. The second transaction is accepted at cycle 6, and `done` pulses at cycles 5 and 11.
- **Macro undefined, P=4, read:** `done` at cycle 9, `cs_n` low through cycles 1-8, `rd_n`=0 in cycles 5-8.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus engine.
`timescale 1ns/1ps
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_DONE
    } state_t;

    localparam int unsigned PHASE_CYCLES_DEF = 74;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter timing each bus phase; zero flags the last cycle.
`timescale 1ns/1ps
module rtc_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_engine.sv
// Executes one RTC register read/write on the multiplexed address/data bus.
// Macro RTC_BUS_GAP_EN adds the GAP1/GAP2 recovery phases around DATA.
`timescale 1ns/1ps
module rtc_bus_engine
    import rtc_bus_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = PHASE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       RW,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

`ifdef RTC_BUS_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [7:0] PHASE_LOAD = 8'(PHASE_CYCLES - 1);

    state_t     state, state_next;
    logic       accept;
    logic       load;
    logic       zero;
    logic       rw_q;
    logic [7:0] addr_q, wdata_q;
    logic       rw_sel;
    logic [7:0] addr_sel, wdata_sel;
    logic       busy_d, done_d, cs_d, rd_d, wr_d, ad_d, oe_d;
    logic [7:0] out_d;

    rtc_phase_timer u_timer (
        .clk        (clk),
        .rst_n      (Reset),
        .load       (load),
        .load_value (PHASE_LOAD),
        .zero       (zero)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_next = S_ADDR;
                accept     = 1'b1;
            end
            S_ADDR:  if (zero) state_next = GAP_EN ? S_GAP1 : S_DATA;
            S_GAP1:  if (zero) state_next = S_DATA;
            S_DATA:  if (zero) state_next = GAP_EN ? S_GAP2 : S_DONE;
            S_GAP2:  if (zero) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign load = (state_next != state) &&
                  (state_next inside {S_ADDR, S_GAP1, S_DATA, S_GAP2});

    // Outputs are registered from the next state, so the accepting edge must
    // see the live inputs rather than the not-yet-updated latches.
    assign rw_sel    = accept ? RW    : rw_q;
    assign addr_sel  = accept ? addr  : addr_q;
    assign wdata_sel = accept ? wdata : wdata_q;

    always_comb begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        ad_d   = 1'b1;
        oe_d   = 1'b0;
        out_d  = '0;
        busy_d = (state_next != S_IDLE);
        done_d = (state_next == S_DONE);
        case (state_next)
            S_ADDR: begin
                cs_d  = 1'b0;
                ad_d  = 1'b0;
                wr_d  = 1'b0;
                oe_d  = 1'b1;
                out_d = addr_sel;
            end
            S_DATA: begin
                cs_d = 1'b0;
                if (rw_sel == RW_READ) begin
                    rd_d = 1'b0;
                end else begin
                    wr_d  = 1'b0;
                    oe_d  = 1'b1;
                    out_d = wdata_sel;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            rw_q    <= RW_WRITE;
            addr_q  <= '0;
            wdata_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad_n    <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= '0;
            rdata   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rw_q    <= RW;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            busy   <= busy_d;
            done   <= done_d;
            cs_n   <= cs_d;
            rd_n   <= rd_d;
            wr_n   <= wr_d;
            ad_n   <= ad_d;
            ad_oe  <= oe_d;
            ad_out <= out_d;
            if (state == S_DATA && zero && rw_q == RW_READ) begin
                rdata <= ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_engine.sv
// Bench for rtc_bus_engine: P=4 and P=1 instances against a cycle-index reference model.
`timescale 1ns/1ps
module tb_rtc_bus_engine;

`ifdef RTC_BUS_GAP_EN
    localparam int NPH = 4;
`else
    localparam int NPH = 2;
`endif

    logic       clk   = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic       RW    = 1'b0;
    logic [7:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic [7:0] ad_in = '0;

    logic       busy4, done4, cs_n4, rd_n4, wr_n4, ad_n4, ad_oe4;
    logic [7:0] ad_out4, rdata4;
    logic       busy1, done1, cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1;
    logic [7:0] ad_out1, rdata1;
    logic [22:0] obs4, obs1;

    int  n_chk  = 0;
    int  n_pass = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    rtc_bus_engine #(.PHASE_CYCLES(4)) u_p4 (
        .clk(clk), .Reset(Reset), .start(start), .RW(RW), .addr(addr), .wdata(wdata),
        .busy(busy4), .done(done4), .rdata(rdata4), .cs_n(cs_n4), .rd_n(rd_n4),
        .wr_n(wr_n4), .ad_n(ad_n4), .ad_out(ad_out4), .ad_oe(ad_oe4), .ad_in(ad_in)
    );

    rtc_bus_engine #(.PHASE_CYCLES(1)) u_p1 (
        .clk(clk), .Reset(Reset), .start(start), .RW(RW), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1), .cs_n(cs_n1), .rd_n(rd_n1),
        .wr_n(wr_n1), .ad_n(ad_n1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in)
    );

    assign obs4 = {busy4, done4, cs_n4, rd_n4, wr_n4, ad_n4, ad_oe4, ad_out4, rdata4};
    assign obs1 = {busy1, done1, cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, ad_out1, rdata1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: k = cycle index since acceptance (0 = idle); phase = (k-1)/P.
    int         mk [2]  = '{0, 0};
    logic       mrw[2]  = '{1'b0, 1'b0};
    logic [7:0] mad[2]  = '{8'h00, 8'h00};
    logic [7:0] mwd[2]  = '{8'h00, 8'h00};
    logic [7:0] mrd[2]  = '{8'h00, 8'h00};

    function automatic int p_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(posedge clk or negedge Reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!Reset) begin
                mk[i]  = 0;
                mrd[i] = 8'h00;
            end else if (mk[i] == 0) begin
                if (start) begin
                    mk[i] = 1; mrw[i] = RW; mad[i] = addr; mwd[i] = wdata;
                end
            end else begin
                if (mrw[i] && mk[i] == (NPH / 2 + 1) * p_of(i)) mrd[i] = ad_in;
                mk[i] = (mk[i] == NPH * p_of(i) + 1) ? 0 : mk[i] + 1;
            end
        end
    end

    function automatic logic [22:0] model_out(input int k, input int p, input logic rw,
                                              input logic [7:0] a, input logic [7:0] w,
                                              input logic [7:0] rd);
        logic b, d, cs, rdn, wrn, adn, oe;
        logic [7:0] ao;
        int ph;
        b = (k != 0); d = (k == NPH * p + 1);
        cs = 1'b1; rdn = 1'b1; wrn = 1'b1; adn = 1'b1; oe = 1'b0; ao = 8'h00;
        if (b && !d) begin
            ph = (k - 1) / p;
            if (ph == 0) begin
                cs = 1'b0; adn = 1'b0; wrn = 1'b0; oe = 1'b1; ao = a;
            end else if (ph == NPH / 2) begin
                cs = 1'b0;
                if (rw) rdn = 1'b0;
                else begin wrn = 1'b0; oe = 1'b1; ao = w; end
            end
        end
        return {b, d, cs, rdn, wrn, adn, oe, ao, rd};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_p4", 32'(obs4), 32'(model_out(mk[0], 4, mrw[0], mad[0], mwd[0], mrd[0])));
            check("cyc_p1", 32'(obs1), 32'(model_out(mk[1], 1, mrw[1], mad[1], mwd[1], mrd[1])));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy4 || busy1) && n < 200) begin @(negedge clk); n++; end
        check("idle", 32'(busy4 | busy1), 32'd0);
    endtask

    // Drives one start pulse on the P=4 instance and returns the cycle number of its done.
    task automatic run_p4(input logic rw, input logic [7:0] a, input logic [7:0] w,
                          input int ign_cyc, output int done_cyc, output int n_done);
        int n;
        RW = rw; addr = a; wdata = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0; RW = ~rw; addr = ~a; wdata = ~w;
        check("addr_c1", 32'(ad_out4), 32'(a));
        n = 1; done_cyc = -1; n_done = 0;
        while (n < NPH * 4 + 6) begin
            if (done4) begin n_done++; if (done_cyc < 0) done_cyc = n; end
            start = (n + 1 == ign_cyc);
            if (start) addr = 8'h99;
            @(negedge clk); n++;
        end
        start = 1'b0;
    endtask

    initial begin
        int dc, nd, d1, d2, n;
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset", 32'(obs4), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00}));
        Reset = 1'b1;
        @(negedge clk);

        // Write 0x35 to 0x21
        run_p4(1'b0, 8'h21, 8'h35, 0, dc, nd);
        check("wr_lat", 32'(dc), 32'(NPH * 4 + 1));
        wait_idle();

        // Read 0x22, bus returns 0x59
        ad_in = 8'h59;
        run_p4(1'b1, 8'h22, 8'h00, 0, dc, nd);
        check("rd_lat", 32'(dc), 32'(NPH * 4 + 1));
        check("rd_data", 32'(rdata4), 32'h59);
        ad_in = 8'h00;
        wait_idle();

        // Ignored start at cycle 6
        run_p4(1'b0, 8'h44, 8'h55, 6, dc, nd);
        check("ign_ndone", 32'(nd), 32'd1);
        check("ign_lat", 32'(dc), 32'(NPH * 4 + 1));
        wait_idle();

        // Reset in the middle of a read
        RW = 1'b1; addr = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ((NPH == 4) ? 8 : 4) @(negedge clk);
        @(posedge clk);
        #2 Reset = 1'b0;
        #1 check("rst_mid", 32'({busy4, cs_n4, rd_n4, wr_n4, ad_n4, ad_oe4, done4}), 32'b0111100);
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        nd = 0;
        for (int i = 0; i < NPH * 4 + 4; i++) begin @(negedge clk); nd += int'(done4); end
        check("rst_nodone", 32'(nd), 32'd0);
        ad_in = 8'hA6;
        run_p4(1'b1, 8'h23, 8'h00, 0, dc, nd);
        check("rst_rd_lat", 32'(dc), 32'(NPH * 4 + 1));
        check("rst_rd_data", 32'(rdata4), 32'hA6);
        wait_idle();

        // P=1 back-to-back writes with start held high
        RW = 1'b0; addr = 8'h10; wdata = 8'h20; start = 1'b1;
        @(negedge clk);
        d1 = -1; d2 = -1; n = 1;
        while (n <= 2 * NPH + 3) begin
            if (done1) begin if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n; end
            if (n == 2 * NPH + 3) start = 1'b0;
            @(negedge clk); n++;
        end
        start = 1'b0;
        check("b2b_done1", 32'(d1), 32'(NPH + 2 - 1));
        check("b2b_done2", 32'(d2), 32'(2 * NPH + 3));
        wait_idle();

        // Random traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            RW    = 1'($urandom);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            ad_in = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #3 Reset = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #3 Reset = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
